// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: a handshaked config selects IDLE/BLINK/CHASE/COUNT,
// and a prescaler plus per-step counter pace the pattern advance.
module led_seq_ctrl #(
  parameter int unsigned CLK_DIV = 10,
  parameter int unsigned N_LED   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_mode,
  input  logic [7:0]       cfg_period,
  output logic [N_LED-1:0] led,
  output logic             step,
  output logic             active
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLINK = 2'd1,
    ST_CHASE = 2'd2,
    ST_COUNT = 2'd3
  } state_t;

  localparam logic [7:0]       PRESC_TC = 8'(CLK_DIV);
  localparam logic [N_LED-1:0] LED_ONE  = N_LED'(1);

  state_t           state_q, state_d;
  logic [7:0]       period_q, period_d;
  logic [7:0]       presc_q, presc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [N_LED-1:0] led_q, led_d;
  logic             ready_q, ready_d;
  logic             active_q, active_d;

  logic accept;
  logic tick;
  logic step_evt;

  always_comb begin
    accept   = cfg_valid && ready_q;
    tick     = (presc_q == PRESC_TC);
    step_evt = (state_q != ST_IDLE) && tick && (cnt_q == period_q);

    state_d  = state_q;
    period_d = period_q;
    presc_d  = presc_q;
    cnt_d    = cnt_q;
    led_d    = led_q;
    ready_d  = !accept;

    if (accept) begin
      // A new configuration overrides any coincident step event.
      state_d  = state_t'(cfg_mode);
      period_d = cfg_period;
      presc_d  = '0;
      cnt_d    = '0;
      led_d    = (state_t'(cfg_mode) == ST_CHASE) ? LED_ONE : '0;
    end else if (state_q != ST_IDLE) begin
      presc_d = tick ? '0 : presc_q + 8'd1;
      if (tick) begin
        cnt_d = (cnt_q == period_q) ? '0 : cnt_q + 8'd1;
      end
      if (step_evt) begin
        unique case (state_q)
          ST_BLINK: led_d = ~led_q;
          ST_CHASE: led_d = {led_q[N_LED-2:0], led_q[N_LED-1]};
          ST_COUNT: led_d = led_q + LED_ONE;
          default:  led_d = '0;
        endcase
      end
    end

    active_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      period_q <= '0;
      presc_q  <= '0;
      cnt_q    <= '0;
      led_q    <= '0;
      ready_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      led_q    <= led_d;
      ready_q  <= ready_d;
      active_q <= active_d;
    end
  end

  assign cfg_ready = ready_q;
  assign led       = led_q;
  assign step      = step_evt && !accept;
  assign active    = active_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl: a time-since-acceptance model predicts
// every output each cycle, plus literal checkpoints for the key scenarios.
module tb_led_seq_ctrl;

  localparam int unsigned CLK_DIV = 10;
  localparam int unsigned N_LED   = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [1:0]       cfg_mode = 2'd0;
  logic [7:0]       cfg_period = 8'd0;
  logic [N_LED-1:0] led;
  logic             step;
  logic             active;

  int errors = 0;
  int checks = 0;

  led_seq_ctrl #(.CLK_DIV(CLK_DIV), .N_LED(N_LED)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_mode  (cfg_mode),
    .cfg_period(cfg_period),
    .led       (led),
    .step      (step),
    .active    (active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode, period and the number of edges elapsed since acceptance.
  int m_mode = 0;
  int m_period = 0;
  int m_t = 0;
  bit m_ready = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_period = 0; m_t = 0; m_ready = 1'b0;
    end else begin
      if (cfg_valid && m_ready) begin
        m_mode = int'(cfg_mode); m_period = int'(cfg_period); m_t = 0;
        m_ready = 1'b0;
      end else begin
        if (m_mode != 0) m_t++;
        m_ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    int per, n;
    logic [N_LED-1:0] e_led;
    logic e_step;
    per = (m_period + 1) * int'(CLK_DIV + 1);
    n = m_t / per;
    case (m_mode)
      1: e_led = (n % 2 == 1) ? '1 : '0;
      2: e_led = N_LED'(1) << (n % N_LED);
      3: e_led = N_LED'(n);
      default: e_led = '0;
    endcase
    e_step = (m_mode != 0) && ((m_t + 1) % per == 0) && !(cfg_valid && m_ready) && !rst;
    chk("led", 32'(led), 32'(e_led));
    chk("step", 32'(step), 32'(e_step));
    chk("active", 32'(active), 32'(m_mode != 0));
    chk("cfg_ready", 32'(cfg_ready), 32'(m_ready));
  end

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a request after a drive point; return 1ns after the accepting edge.
  task automatic send(input logic [1:0] mode, input logic [7:0] period);
    cfg_valid = 1'b1; cfg_mode = mode; cfg_period = period;
    tick_n(1);
    cfg_valid = 1'b0;
  endtask

  initial begin
    tick_n(2);
    rst = 1'b0;
    tick_n(100);
    chk("idle_led", 32'(led), 32'h0);
    chk("idle_active", 32'(active), 32'h0);
    chk("idle_ready", 32'(cfg_ready), 32'h1);

    // BLINK, period 0
    send(2'd1, 8'd0);
    chk("blink_load", 32'(led), 32'h0);
    chk("blink_ready_low", 32'(cfg_ready), 32'h0);
    tick_n(10);
    chk("blink_step_pulse", 32'(step), 32'h1);
    tick_n(1);
    chk("blink_11", 32'(led), 32'hF);
    tick_n(11);
    chk("blink_22", 32'(led), 32'h0);

    // CHASE, period 2
    send(2'd2, 8'd2);
    chk("chase_load", 32'(led), 32'h1);
    tick_n(33);
    chk("chase_33", 32'(led), 32'h2);
    tick_n(66);
    chk("chase_99", 32'(led), 32'h8);
    tick_n(33);
    chk("chase_wrap", 32'(led), 32'h1);

    // COUNT, period 0, 16 steps
    send(2'd3, 8'd0);
    chk("count_load", 32'(led), 32'h0);
    tick_n(15 * 11);
    chk("count_15", 32'(led), 32'hF);
    tick_n(11);
    chk("count_wrap", 32'(led), 32'h0);

    // Acceptance coinciding with a step event
    send(2'd2, 8'd0);
    tick_n(10);
    chk("pre_collide_step", 32'(step), 32'h1);
    cfg_valid = 1'b1; cfg_mode = 2'd3; cfg_period = 8'd0;
    #1;
    chk("collide_step_suppressed", 32'(step), 32'h0);
    tick_n(1);
    cfg_valid = 1'b0;
    chk("collide_led", 32'(led), 32'h0);
    tick_n(10);
    chk("collide_next_step", 32'(step), 32'h1);
    tick_n(1);
    chk("collide_led_after", 32'(led), 32'h1);

    // Asynchronous reset mid-BLINK
    send(2'd1, 8'd0);
    tick_n(13);
    #2;
    rst = 1'b1;
    #1;
    chk("async_led", 32'(led), 32'h0);
    chk("async_active", 32'(active), 32'h0);
    chk("async_ready", 32'(cfg_ready), 32'h0);
    tick_n(1);
    rst = 1'b0;
    tick_n(1);
    chk("post_rst_active", 32'(active), 32'h0);
    chk("post_rst_ready", 32'(cfg_ready), 32'h1);

    // Randomized requests and occasional resets
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
        cfg_valid = 1'b0;
        tick_n($urandom_range(1, 3));
        rst = 1'b0;
      end else if ($urandom_range(0, 39) == 0) begin
        cfg_valid = 1'b1;
        cfg_mode = 2'($urandom_range(0, 3));
        cfg_period = 8'($urandom_range(0, 3));
        tick_n(1);
      end else begin
        cfg_valid = 1'b0;
        tick_n(1);
      end
    end
    cfg_valid = 1'b0;
    tick_n(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
